ibus_imem_responder: RTL and testbench

- Responder (slave) end of the 19-bit instruction bus driven by the fetch stage: accepts `ibus_valid`/`ibus_addr` requests and returns 19-bit instruction words with fixed, parameterised latency.
- Holds on-chip instruction memory, cleared by a post-reset init sequence.
- A side-band load port, used by the boot loader or testbench, writes program words.
- Sits between the fetch stage and the instruction RAM; provides `ibus_ready` so fetch stalls during init and load.

---
 rtl/ibus_imem_responder.sv | 169 ++++++++++++++++
 tb/tb_ibus_imem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_imem_responder.sv
// rtl/ibus_imem_responder.sv - instruction-bus responder with on-chip instruction memory
//
// Purpose: answers fetch requests on the instruction bus with a fixed,
// parameterised latency. The memory is cleared by a post-reset INIT sweep.
// A side-band load port writes program words.
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per word.
// A parity mismatch on read raises ibus_err. This build also adds the
// inj_parity_flip input.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   ibus_valid/addr  fetch request
//   ibus_ready       request accepted when ibus_valid & ibus_ready at an edge
//   ibus_rdata       response word, held while ibus_rvalid is low
//   ibus_rvalid      one-cycle pulse per accepted request, in order
//   ibus_err         qualifies ibus_rvalid: out-of-range address (or parity error)
//   load_en/addr/data program-load write port (ignored during INIT)
//   inj_parity_flip  (IMEM_PARITY_EN only) invert stored parity of this load
//   init_done        memory clear complete
module ibus_imem_responder #(
  parameter int                ADDR_W   = 19,
  parameter int                DATA_W   = 19,
  parameter int                DEPTH    = 1024,  // power of two, >= 2
  parameter int                LATENCY  = 1,     // 1..4
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ibus_valid,
  input  logic [ADDR_W-1:0] ibus_addr,
  output logic              ibus_ready,
  output logic [DATA_W-1:0] ibus_rdata,
  output logic              ibus_rvalid,
  output logic              ibus_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic              inj_parity_flip,
`endif
  output logic              init_done
);

  localparam int CNT_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;  // parity bit in the MSB
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MEM_W-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [CNT_W-1:0]   mem_waddr;
  logic [MEM_W-1:0]   mem_wdata;

  logic               vld_q [LATENCY];
  logic               vld_d [LATENCY];
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];
  logic               err_q [LATENCY];
  logic               err_d [LATENCY];

  logic               load_in_range;
  logic               fetch_in_range;
  logic               accept;
  logic [MEM_W-1:0]   rd_word;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_err;

  // Zero-extend by one bit so DEPTH == 2**ADDR_W still compares correctly.
  assign load_in_range  = {1'b0, load_addr} < (ADDR_W + 1)'(DEPTH);
  assign fetch_in_range = {1'b0, ibus_addr} < (ADDR_W + 1)'(DEPTH);
  assign accept         = ibus_valid & ibus_ready;

  // The read is taken at the accept edge, so a later load cannot change it.
  assign rd_word = mem_q[ibus_addr[CNT_W-1:0]];
  assign rd_data = fetch_in_range ? rd_word[DATA_W-1:0] : NOP_WORD;
`ifdef IMEM_PARITY_EN
  // Even parity across data+parity bit; any odd count flags corruption.
  assign rd_err  = !fetch_in_range || (^rd_word);
`else
  assign rd_err  = !fetch_in_range;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = cnt_q;
    mem_wdata  = '0;
    ibus_ready = 1'b0;
    init_done  = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        init_done  = 1'b1;
        // A load owns the cycle; fetch stalls.
        ibus_ready = !load_en;
        if (load_en && load_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[CNT_W-1:0];
`ifdef IMEM_PARITY_EN
          mem_wdata = {(^load_data) ^ inj_parity_flip, load_data};
`else
          mem_wdata = load_data;
`endif
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Response pipeline: data fields only advance with their valid bit so the
  // last stage holds the most recent response while rvalid is low.
  always_comb begin
    vld_d[0] = accept;
    dat_d[0] = accept ? rd_data : dat_q[0];
    err_d[0] = accept ? rd_err  : err_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      err_d[i] = vld_q[i-1] ? err_q[i-1] : err_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
        err_q[i] <= err_d[i];
      end
    end
  end

  // Storage array has no reset; INIT clears it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ibus_rvalid = vld_q[LATENCY-1];
  assign ibus_rdata  = dat_q[LATENCY-1];
  assign ibus_err    = vld_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: tb/tb_ibus_imem_responder.sv
// tb/tb_ibus_imem_responder.sv - bench for ibus_imem_responder at latencies 1, 3 and 4
module tb_ibus_imem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [18:0] NOP   = 19'h00013;
  localparam int          HMAX  = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_valid;
  logic [18:0] ibus_addr;
  logic        load_en;
  logic [18:0] load_addr;
  logic [18:0] load_data;

  logic [2:0]  rdy, rv, er, dn;
  logic [18:0] rd [3];

  always #5 clk = ~clk;

  ibus_imem_responder #(.DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(NOP)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .ibus_valid(ibus_valid), .ibus_addr(ibus_addr),
    .ibus_ready(rdy[0]), .ibus_rdata(rd[0]), .ibus_rvalid(rv[0]), .ibus_err(er[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .init_done(dn[0]));

  ibus_imem_responder #(.DEPTH(DEPTH), .LATENCY(3), .NOP_WORD(NOP)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .ibus_valid(ibus_valid), .ibus_addr(ibus_addr),
    .ibus_ready(rdy[1]), .ibus_rdata(rd[1]), .ibus_rvalid(rv[1]), .ibus_err(er[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .init_done(dn[1]));

  ibus_imem_responder #(.DEPTH(DEPTH), .LATENCY(4), .NOP_WORD(NOP)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .ibus_valid(ibus_valid), .ibus_addr(ibus_addr),
    .ibus_ready(rdy[2]), .ibus_rdata(rd[2]), .ibus_rvalid(rv[2]), .ibus_err(er[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .init_done(dn[2]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents, init progress and per-edge accept log.
  int          lat [3] = '{1, 3, 4};
  logic [18:0] mem_m [DEPTH];
  int          init_cnt;
  logic        m_done;
  int          cyc;
  int          base;
  logic        acc_h [HMAX];
  logic [18:0] d_h [HMAX];
  logic        e_h [HMAX];
  logic [18:0] last_d [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    init_cnt = 0;
    m_done   = 1'b0;
    base     = cyc;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int j = 0; j < 3; j++) last_d[j] = '0;
  endtask

  task automatic check_reset_outputs();
    for (int j = 0; j < 3; j++) begin
      check("rst_ready",  {31'd0, rdy[j]}, 32'd0);
      check("rst_rvalid", {31'd0, rv[j]},  32'd0);
      check("rst_err",    {31'd0, er[j]},  32'd0);
      check("rst_rdata",  {13'd0, rd[j]},  32'd0);
      check("rst_done",   {31'd0, dn[j]},  32'd0);
    end
  endtask

  // One clock: inputs must already be applied by the caller.
  task automatic tick();
    logic        m_ready, acc, e;
    logic [18:0] d;
    int          idx;
    #1;
    m_ready = m_done && !load_en;
    for (int j = 0; j < 3; j++) begin
      check("ready",     {31'd0, rdy[j]}, {31'd0, m_ready});
      check("init_done", {31'd0, dn[j]},  {31'd0, m_done});
    end
    acc = ibus_valid && m_ready;
    if (ibus_addr < DEPTH) begin
      d = mem_m[ibus_addr];
      e = 1'b0;
    end else begin
      d = NOP;
      e = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    acc_h[cyc] = acc;
    d_h[cyc]   = d;
    e_h[cyc]   = e;
    if (!m_done) begin
      init_cnt++;
      if (init_cnt == DEPTH) m_done = 1'b1;
    end else if (load_en && load_addr < DEPTH) begin
      mem_m[load_addr] = load_data;
    end
    for (int j = 0; j < 3; j++) begin
      idx = cyc - lat[j] + 1;
      if (idx > base && acc_h[idx]) begin
        check("rvalid", {31'd0, rv[j]}, 32'd1);
        check("rdata",  {13'd0, rd[j]}, {13'd0, d_h[idx]});
        check("err",    {31'd0, er[j]}, {31'd0, e_h[idx]});
        last_d[j] = d_h[idx];
      end else begin
        check("rvalid_idle", {31'd0, rv[j]}, 32'd0);
        check("rdata_hold",  {13'd0, rd[j]}, {13'd0, last_d[j]});
        check("err_idle",    {31'd0, er[j]}, 32'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    ibus_valid = 1'b0;
    load_en    = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [18:0] a, input logic [18:0] v);
    load_en = 1'b1; load_addr = a; load_data = v; ibus_valid = 1'b0;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_fetch(input logic [18:0] a);
    ibus_valid = 1'b1; ibus_addr = a; load_en = 1'b0;
    tick();
    ibus_valid = 1'b0;
  endtask

  logic [18:0] prog [4];

  initial begin
    prog = '{19'h12345, 19'h00001, 19'h7FFFF, 19'h2AAAA};
    rst_n = 1'b0; ibus_valid = 1'b0; ibus_addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;

    // INIT with a fetch held pending and loads that must be ignored.
    ibus_valid = 1'b1; ibus_addr = 19'd5;
    for (int i = 0; i < DEPTH; i++) begin
      load_en = (i % 7 == 0); load_addr = 19'd5; load_data = 19'h55555;
      tick();
    end
    load_en = 1'b0;
    do_fetch(19'd5);
    idle(5);

    for (int i = 0; i < 4; i++) do_load(19'(i), prog[i]);
    for (int i = 0; i < 4; i++) begin
      ibus_valid = 1'b1; ibus_addr = 19'(i); tick();
    end
    idle(5);

    do_fetch(19'd2);
    idle(5);

    // Load and fetch in the same cycle: load wins, fetch lands next cycle.
    ibus_valid = 1'b1; ibus_addr = 19'd7;
    load_en = 1'b1; load_addr = 19'd7; load_data = 19'h3C3C3;
    tick();
    load_en = 1'b0;
    tick();
    idle(5);

    do_fetch(19'd1024);
    do_fetch(19'd1023);
    do_load(19'd2000, 19'h11111);
    do_load(19'd1024, 19'h22222);
    for (int i = 0; i < 4; i++) do_fetch(19'(i));
    do_fetch(19'(2000 % DEPTH));
    idle(5);

    for (int i = 0; i < 800; i++) begin
      ibus_valid = ($urandom_range(0, 3) != 0);
      ibus_addr  = ($urandom_range(0, 4) == 0) ? 19'($urandom_range(1018, 1030))
                                               : 19'($urandom_range(0, 15));
      load_en    = ($urandom_range(0, 3) == 0);
      load_addr  = ($urandom_range(0, 5) == 0) ? 19'($urandom_range(1020, 2047))
                                               : 19'($urandom_range(0, 15));
      load_data  = 19'($urandom);
      tick();
    end
    idle(6);

    // Reset with two requests still in flight.
    do_load(19'd9, 19'h6DB6D);
    ibus_valid = 1'b1; ibus_addr = 19'd9; tick();
    ibus_addr = 19'd0; tick();
    ibus_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1 check_reset_outputs();
      @(posedge clk);
    end
    @(negedge clk) rst_n = 1'b1;
    ibus_valid = 1'b1; ibus_addr = 19'd9;
    for (int i = 0; i < DEPTH; i++) tick();
    do_fetch(19'd9);
    do_fetch(19'd0);
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
